// File: rtl/dino_motion_pkg.sv
// Shared dino game definitions: motion FSM encoding and default geometry/physics.
// The VGA path pulls GROUND_Y and X_POS from here so sprite and motion agree.
package dino_motion_pkg;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_DUCK   = 2'd1,
        ST_RISE   = 2'd2,
        ST_FALL   = 2'd3
    } dino_state_e;

    localparam int DINO_X_POS        = 50;
    localparam int DINO_GROUND_Y     = 275;
    localparam int DINO_JUMP_V       = 12;
    localparam int DINO_GRAVITY      = 1;
    localparam int DINO_FAST_GRAVITY = 3;

    localparam int VEL_W = 8;
    localparam int Y_W   = 10;

    // Velocity magnitude add that pins at the 8-bit ceiling instead of wrapping.
    function automatic logic [VEL_W-1:0] vel_sat_add(input logic [VEL_W-1:0] a,
                                                     input logic [VEL_W-1:0] b);
        logic [VEL_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[VEL_W] ? {VEL_W{1'b1}} : s[VEL_W-1:0];
    endfunction

endpackage

// File: rtl/dino_motion_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a one-clk rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    // [0],[1] synchronize; [2] holds the previous synced value for edge detect.
    logic [2:0] sh_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sh_q <= 3'b000;
        else       sh_q <= {sh_q[1:0], async_i};
    end

    assign level_o = sh_q[1];
    assign rise_o  = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/dino_motion.sv
// Dino vertical motion: per-frame jump/duck/fall physics stepped on a frame tick
// derived from the VGA screen_end level.
module dino_motion
    import dino_motion_pkg::*;
#(
    parameter int X_POS        = DINO_X_POS,
    parameter int GROUND_Y     = DINO_GROUND_Y,
    parameter int JUMP_V       = DINO_JUMP_V,
    parameter int GRAVITY      = DINO_GRAVITY,
    parameter int FAST_GRAVITY = DINO_FAST_GRAVITY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        up,
    input  logic        down,
    input  logic        screen_end,
    input  logic        game_on,
    input  logic        game_over,
    output logic [31:0] dino_x,
    output logic [31:0] dino_y,
    output logic        airborne,
    output logic        ducking
);

    localparam logic [Y_W-1:0]   Y_GROUND = Y_W'(GROUND_Y);
    localparam logic [VEL_W-1:0] V_JUMP   = VEL_W'(JUMP_V);
    localparam logic [VEL_W-1:0] G_NORM   = VEL_W'(GRAVITY);
    localparam logic [VEL_W-1:0] G_FAST   = VEL_W'(FAST_GRAVITY);

    logic up_lvl, up_rise;
    logic down_lvl, down_rise;
    logic se_lvl, tick;

    sync_edge u_sync_up (.clk(clk), .reset(reset), .async_i(up),
                         .level_o(up_lvl), .rise_o(up_rise));
    sync_edge u_sync_down (.clk(clk), .reset(reset), .async_i(down),
                           .level_o(down_lvl), .rise_o(down_rise));
    sync_edge u_sync_frame (.clk(clk), .reset(reset), .async_i(screen_end),
                            .level_o(se_lvl), .rise_o(tick));

    logic unused_sync;
    assign unused_sync = up_lvl ^ down_rise ^ se_lvl;

    // A new up edge wins over the tick clear, so a coincident press survives
    // while the FSM consumes the value latched before it.
    logic jump_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        jump_q <= 1'b0;
        else if (up_rise) jump_q <= 1'b1;
        else if (tick)    jump_q <= 1'b0;
    end

    dino_state_e      state_q;
    logic [Y_W-1:0]   y_q;
    logic [VEL_W-1:0] vel_q;
    logic             airborne_q, ducking_q;

    logic [VEL_W-1:0] g;
    logic [Y_W:0]     fall_sum;
    logic             step;

    assign g        = down_lvl ? G_FAST : G_NORM;
    assign fall_sum = {1'b0, y_q} + {{(Y_W+1-VEL_W){1'b0}}, vel_q};
    assign step     = tick & game_on & ~game_over;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_GROUND;
            y_q        <= Y_GROUND;
            vel_q      <= '0;
            airborne_q <= 1'b0;
            ducking_q  <= 1'b0;
        end else if (step) begin
            unique case (state_q)
                ST_GROUND, ST_DUCK: begin
                    if (jump_q) begin
                        state_q    <= ST_RISE;
                        vel_q      <= V_JUMP;
                        airborne_q <= 1'b1;
                        ducking_q  <= 1'b0;
                    end else if (down_lvl) begin
                        state_q   <= ST_DUCK;
                        ducking_q <= 1'b1;
                    end else begin
                        state_q   <= ST_GROUND;
                        ducking_q <= 1'b0;
                    end
                end
                ST_RISE: begin
                    y_q <= y_q - {{(Y_W-VEL_W){1'b0}}, vel_q};
                    if (vel_q <= g) begin
                        vel_q   <= '0;
                        state_q <= ST_FALL;
                    end else begin
                        vel_q <= vel_q - g;
                    end
                end
                ST_FALL: begin
                    // Clamp to the ground line so landing never overshoots.
                    if (fall_sum >= {1'b0, Y_GROUND}) begin
                        y_q        <= Y_GROUND;
                        vel_q      <= '0;
                        state_q    <= ST_GROUND;
                        airborne_q <= 1'b0;
                    end else begin
                        y_q   <= fall_sum[Y_W-1:0];
                        vel_q <= vel_sat_add(vel_q, g);
                    end
                end
                default: state_q <= ST_GROUND;
            endcase
        end
    end

    assign dino_x   = 32'(X_POS);
    assign dino_y   = {{(32-Y_W){1'b0}}, y_q};
    assign airborne = airborne_q;
    assign ducking  = ducking_q;

endmodule

// File: tb/tb_dino_motion.sv
// Directed bench for dino_motion: jump arc, fast fall, duck, freeze and reset.
module tb_dino_motion;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        up = 1'b0, down = 1'b0, screen_end = 1'b0;
    logic        game_on = 1'b0, game_over = 1'b0;
    logic [31:0] dino_x, dino_y;
    logic        airborne, ducking;

    int errors = 0;
    int checks = 0;

    dino_motion dut (
        .clk(clk), .reset(reset), .up(up), .down(down), .screen_end(screen_end),
        .game_on(game_on), .game_over(game_over),
        .dino_x(dino_x), .dino_y(dino_y), .airborne(airborne), .ducking(ducking)
    );

    always #5 clk = ~clk;

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int hi);
        @(posedge clk); #1;
        screen_end = 1'b1;
        clks(hi);
        screen_end = 1'b0;
        clks(6);
    endtask

    task automatic press_up();
        @(posedge clk); #1;
        up = 1'b1;
        clks(3);
        up = 1'b0;
        clks(3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clks(3);
        reset = 1'b0;
        clks(2);
        checks++; if (dino_x !== 32'd50) begin errors++; $display("FAIL reset_x got=%0d exp=50", dino_x); end
        checks++; if (dino_y !== 32'd275) begin errors++; $display("FAIL reset_y got=%0d exp=275", dino_y); end
        checks++; if (airborne !== 1'b0) begin errors++; $display("FAIL reset_air got=%b exp=0", airborne); end
        checks++; if (ducking !== 1'b0) begin errors++; $display("FAIL reset_duck got=%b exp=0", ducking); end
    endtask

    task automatic test_freeze();
        game_on = 1'b0;
        press_up();
        frame(6);
        checks++; if (airborne !== 1'b0 || dino_y !== 32'd275) begin
            errors++; $display("FAIL freeze_off got y=%0d air=%b exp y=275 air=0", dino_y, airborne); end
        game_on = 1'b1;
        frame(6);
        checks++; if (airborne !== 1'b0) begin
            errors++; $display("FAIL freeze_req_cleared got air=%b exp=0", airborne); end
    endtask

    task automatic test_jump_arc();
        int exp_y[26] = '{275,263,252,242,233,225,218,212,207,203,200,198,197,
                          197,198,200,203,207,212,218,225,233,242,252,263,275};
        press_up();
        for (int i = 0; i < 26; i++) begin
            frame(6);
            checks++; if (dino_y !== 32'(exp_y[i])) begin
                errors++; $display("FAIL arc_y tick=%0d got=%0d exp=%0d", i + 1, dino_y, exp_y[i]); end
            checks++; if (airborne !== (i < 25)) begin
                errors++; $display("FAIL arc_air tick=%0d got=%b exp=%b", i + 1, airborne, (i < 25)); end
        end
    endtask

    task automatic test_fast_fall();
        int exp_y[10] = '{242,235,231,230,230,233,239,248,260,275};
        press_up();
        repeat (3) frame(6);
        down = 1'b1;
        clks(4);
        for (int i = 0; i < 10; i++) begin
            frame(6);
            checks++; if (dino_y !== 32'(exp_y[i]) || dino_y > 32'd275) begin
                errors++; $display("FAIL fast_y step=%0d got=%0d exp=%0d", i, dino_y, exp_y[i]); end
        end
        checks++; if (airborne !== 1'b0) begin errors++; $display("FAIL fast_land_air got=%b exp=0", airborne); end
        down = 1'b0;
        clks(4);
        frame(6);
    endtask

    task automatic test_duck();
        down = 1'b1;
        clks(4);
        repeat (2) frame(6);
        checks++; if (ducking !== 1'b1 || dino_y !== 32'd275 || airborne !== 1'b0) begin
            errors++; $display("FAIL duck_hold got duck=%b y=%0d air=%b exp duck=1 y=275 air=0", ducking, dino_y, airborne); end
        down = 1'b0;
        clks(4);
        frame(6);
        checks++; if (ducking !== 1'b0) begin errors++; $display("FAIL duck_release got=%b exp=0", ducking); end
        // Jump straight out of a duck.
        down = 1'b1;
        clks(4);
        frame(6);
        press_up();
        frame(6);
        checks++; if (airborne !== 1'b1 || ducking !== 1'b0 || dino_y !== 32'd275) begin
            errors++; $display("FAIL duck_jump got air=%b duck=%b y=%0d exp air=1 duck=0 y=275", airborne, ducking, dino_y); end
        down = 1'b0;
        clks(4);
        for (int i = 0; i < 40 && airborne; i++) frame(6);
        checks++; if (airborne !== 1'b0 || dino_y !== 32'd275) begin
            errors++; $display("FAIL duck_jump_land got air=%b y=%0d exp air=0 y=275", airborne, dino_y); end
    endtask

    task automatic test_game_over();
        press_up();
        repeat (13) frame(6);
        checks++; if (dino_y !== 32'd197) begin errors++; $display("FAIL go_peak got=%0d exp=197", dino_y); end
        game_over = 1'b1;
        for (int i = 0; i < 10; i++) begin
            press_up();
            frame(6);
            checks++; if (dino_y !== 32'd197 || airborne !== 1'b1) begin
                errors++; $display("FAIL go_hold frame=%0d got y=%0d air=%b exp y=197 air=1", i, dino_y, airborne); end
        end
        press_up();
        game_over = 1'b0;
        frame(6);
        frame(6);
        checks++; if (dino_y !== 32'd198 || airborne !== 1'b1) begin
            errors++; $display("FAIL go_resume got y=%0d air=%b exp y=198 air=1", dino_y, airborne); end
        for (int i = 0; i < 40 && airborne; i++) frame(6);
        checks++; if (airborne !== 1'b0 || dino_y !== 32'd275) begin
            errors++; $display("FAIL go_land got air=%b y=%0d exp air=0 y=275", airborne, dino_y); end
    endtask

    task automatic test_reset_midflight();
        press_up();
        repeat (3) frame(6);
        down = 1'b1;
        clks(4);
        repeat (4) frame(6);
        checks++; if (dino_y !== 32'd230 || airborne !== 1'b1) begin
            errors++; $display("FAIL mid_fall_setup got y=%0d air=%b exp y=230 air=1", dino_y, airborne); end
        #2 reset = 1'b1;
        #1;
        checks++; if (dino_y !== 32'd275 || airborne !== 1'b0 || ducking !== 1'b0) begin
            errors++; $display("FAIL mid_reset got y=%0d air=%b duck=%b exp y=275 air=0 duck=0", dino_y, airborne, ducking); end
        down = 1'b0;
        clks(3);
        reset = 1'b0;
        clks(2);
        press_up();
        frame(8);
        checks++; if (dino_y !== 32'd275 || airborne !== 1'b1) begin
            errors++; $display("FAIL one_tick got y=%0d air=%b exp y=275 air=1", dino_y, airborne); end
        frame(8);
        checks++; if (dino_y !== 32'd263) begin errors++; $display("FAIL one_tick_next got=%0d exp=263", dino_y); end
    endtask

    initial begin
        test_reset();
        test_freeze();
        test_jump_arc();
        test_fast_fall();
        test_duck();
        test_game_over();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dino_motion.md
DINO_MOTION -- requirements
Module: dino_motion

Interface
REQ-001 Parameter X_POS, 50, fixed dino left-edge column in pixels.
REQ-002 Parameter GROUND_Y, 275, dino top-row y when standing (ground line 335 minus sprite height 60).
REQ-003 Parameter JUMP_V, 12, initial upward speed in px/frame.
REQ-004 Parameter GRAVITY, 1, per-frame speed change in normal flight.
REQ-005 Parameter FAST_GRAVITY, 3, per-frame speed change while down is held in flight.
REQ-006 clk  input  1  100 MHz system clock; reset is asynchronous and active-high; all state is clocked on posedge clk.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 up  input  1  raw jump button, asynchronous to clk.
REQ-009 down  input  1  raw duck/fast-fall button, asynchronous to clk.
REQ-010 screen_end  input  1  frame-boundary level from the VGA timing path, high for at least 4 clk cycles per frame.
REQ-011 game_on  input  1  game started; motion is frozen while low.
REQ-012 game_over  input  1  collision latched; motion is frozen while high.
REQ-013 dino_x  output  32  sprite left column; always equals X_POS.
REQ-014 dino_y  output  32  sprite top row, unsigned.
REQ-015 airborne  output  1  high in RISE or FALL.
REQ-016 ducking  output  1  high in DUCK.

Function
REQ-017 up and down each pass through a 2-flop synchronizer before any use.
REQ-018 The frame tick is a single-clk pulse generated on the rising edge of screen_end, synchronized through 2 flops and then edge-detected; exactly one tick occurs per screen_end high period.
REQ-019 The jump request latches on the synchronized rising edge of up and clears on the next frame tick, whatever the state.
REQ-020 The FSM has states GROUND, DUCK, RISE and FALL; transitions occur only on a frame tick while game_on=1 and game_over=0, otherwise all state, dino_y and velocity hold.
REQ-021 From GROUND: if a jump request is pending, go to RISE with vel=JUMP_V and dino_y unchanged; else if down is held, go to DUCK; else stay.
REQ-022 From DUCK: if a jump request is pending, go to RISE with vel=JUMP_V; else if down is released, go to GROUND; else stay.
REQ-023 In RISE, on each tick: dino_y -= vel; then vel -= g. If vel <= g before the subtraction, set vel=0 and go to FALL.
REQ-024 In FALL, on each tick: if dino_y+vel >= GROUND_Y, set dino_y=GROUND_Y, vel=0 and go to GROUND; else dino_y += vel and vel += g.
REQ-025 g = FAST_GRAVITY when synchronized down=1 in RISE or FALL, else GRAVITY.
REQ-026 vel is an 8-bit unsigned magnitude saturating at 255; dino_y arithmetic is 10-bit unsigned and is zero-extended onto the 32-bit output.
REQ-027 A jump request arriving in RISE or FALL is discarded at the next tick; there is no double jump.
REQ-028 When a tick coincides with an up edge, the request is latched and the tick consumes the previously latched value; the new request is serviced on the following tick.
REQ-029 Outputs are registered; dino_y changes exactly one clk after the tick pulse.

Reset
REQ-030 On reset: state=GROUND, dino_y=GROUND_Y, vel=0, jump request=0, airborne=0, ducking=0, all synchronizer flops=0.
REQ-031 Reset asserted mid-flight returns the block to the values in REQ-030 asynchronously, with no partial frame update.

Structure
REQ-032 The state encoding and the GROUND_Y, X_POS, JUMP_V, GRAVITY and FAST_GRAVITY defaults belong in the shared dino game package, which the VGA path also uses.
REQ-033 One sub-module, sync_edge (2-flop synchronizer plus rising-edge pulse), is instantiated three times: for up, down and screen_end.

Verification
REQ-034 Reset, then game_on=1, pulse up, then 25 frames -> dino_y sequence 275,263,252,242,...,197 (peak, 78 px), then descends and lands at 275 with airborne=0.
REQ-035 Mid-rise, hold down -> the rise decrements speed by 3 per frame; the fall lands exactly at 275 with no overshoot and no value greater than 275.
REQ-036 Hold down while grounded, 2 frames -> ducking=1 and dino_y=275; release -> ducking=0 on the next tick.
REQ-037 Assert game_over at peak -> dino_y holds at 197 for 10 frames; up presses have no effect.
REQ-038 Assert reset during FALL at dino_y=230 -> dino_y=275 and airborne=0 immediately; screen_end held high for 8 clk -> exactly one tick.
